// File: rtl/hd44780_job_queue.sv
// Job queue and dispatcher for hd44780_controller instruction programs.
// Optional retry-once of failed jobs when H4_JQ_RETRY_EN is defined.
module hd44780_job_queue #(
    parameter int ADDR_BITS   = 8,
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 15,
    parameter int GAP_TICKS   = 0
) (
    input  logic                       CLK_I,
    input  logic                       RST_I,
    input  logic                       i_push,
    input  logic [ADDR_BITS-1:0]       i_push_addr,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic [ADDR_BITS-1:0]       o_start_addr,
    output logic                       o_stb,
    input  logic                       i_busy,
    input  logic                       i_error,
    output logic                       o_active,
    output logic                       o_done,
    output logic                       o_err,
    output logic [7:0]                 o_err_count
);

    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;
    localparam int TW        = $clog2(ACK_TIMEOUT + 1);
    localparam int GW        = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS);
    localparam int GAP_LAST  = (GAP_TICKS > 1) ? GAP_TICKS - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_ACK,
        S_DONE,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         head_q, head_d;
    logic [AW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_BITS-1:0]  start_addr_q, start_addr_d;
    logic                  stb_q, stb_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [7:0]            err_count_q, err_count_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [GW-1:0]         gap_q, gap_d;
`ifdef H4_JQ_RETRY_EN
    logic                  retry_q, retry_d;
`endif

    logic [ADDR_BITS-1:0]  mem_q [DEPTH];

    logic full;
    logic empty;
    logic push_ok;
    logic pop;
    logic fail;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        start_addr_d = start_addr_q;
        stb_d        = 1'b0;
        overflow_d   = i_push && full;
        done_d       = 1'b0;
        err_d        = 1'b0;
        err_count_d  = err_count_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        push_ok      = i_push && !full;
        pop          = 1'b0;
        fail         = 1'b0;
`ifdef H4_JQ_RETRY_EN
        retry_d      = retry_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    start_addr_d = mem_q[head_q];
                    pop          = 1'b1;
                    stb_d        = 1'b1;
                    state_d      = S_STROBE;
                end
            end
            S_STROBE: begin
                tmo_d   = '0;
                state_d = S_ACK;
            end
            S_ACK: begin
                if (i_busy) begin
                    state_d = S_DONE;
                end else if (tmo_q == TW'(ACK_TIMEOUT)) begin
                    fail    = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DONE: begin
                if (!i_busy) begin
                    if (i_error) begin
                        fail = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_LAST)) begin
                    state_d = S_IDLE;
`ifdef H4_JQ_RETRY_EN
                    // Re-dispatch the held address without touching the queue
                    if (retry_q) begin
                        stb_d   = 1'b1;
                        state_d = S_STROBE;
                    end
`endif
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push_ok) begin
            tail_d = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop);

`ifdef H4_JQ_RETRY_EN
        if (done_d) begin
            retry_d = 1'b0;
        end
        if (fail) begin
            if (!retry_q) begin
                retry_d = 1'b1;
            end else begin
                retry_d = 1'b0;
                err_d   = 1'b1;
            end
        end
`else
        err_d = fail;
`endif
        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q      <= S_IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            start_addr_q <= '0;
            stb_q        <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            tmo_q        <= '0;
            gap_q        <= '0;
`ifdef H4_JQ_RETRY_EN
            retry_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            start_addr_q <= start_addr_d;
            stb_q        <= stb_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
`ifdef H4_JQ_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    always_ff @(posedge CLK_I) begin
        if (push_ok) begin
            mem_q[tail_q] <= i_push_addr;
        end
    end

    assign o_full       = full;
    assign o_empty      = empty;
    assign o_count      = count_q;
    assign o_overflow   = overflow_q;
    assign o_start_addr = start_addr_q;
    assign o_stb        = stb_q;
    assign o_active     = (state_q != S_IDLE);
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_err_count  = err_count_q;

endmodule

// File: tb/tb_hd44780_job_queue.sv
// Randomized scoreboard bench for hd44780_job_queue with a behavioural
// controller model and job-level reference model.
module tb_hd44780_job_queue;

    localparam int AB    = 8;
    localparam int DEPTH = 4;
    localparam int AT    = 15;
    localparam int GT    = 3;
    localparam int GAPC  = (GT > 1) ? GT : 1;

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b1;
    logic          i_push = 1'b0;
    logic [AB-1:0] i_push_addr = '0;
    logic          i_busy = 1'b0;
    logic          i_error = 1'b0;
    logic          o_full, o_empty, o_overflow, o_stb;
    logic          o_active, o_done, o_err;
    logic [2:0]    o_count;
    logic [AB-1:0] o_start_addr;
    logic [7:0]    o_err_count;

    hd44780_job_queue #(
        .ADDR_BITS(AB), .DEPTH(DEPTH), .ACK_TIMEOUT(AT), .GAP_TICKS(GT)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .i_push(i_push), .i_push_addr(i_push_addr),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
        .o_overflow(o_overflow),
        .o_start_addr(o_start_addr), .o_stb(o_stb),
        .i_busy(i_busy), .i_error(i_error),
        .o_active(o_active), .o_done(o_done), .o_err(o_err),
        .o_err_count(o_err_count)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {
        bit is_err;
        int when;
    } outc_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            chk_en = 0;
    logic [AB-1:0] addr_q[$];
    outc_t         out_q[$];
    int            acc_total = 0;
    int            disp_total = 0;
    bit            exp_ovf = 0;
    int            err_model = 0;
    bit            prev_stb = 0;
    int            next_min = 0;
    bit            next_exact = 0;
    bit            long_mode = 0;
    int            no_ack_pct = 0;
    int            err_pct = 0;
    int            ctl_phase = 0;
    int            ctl_wait = 0;
    int            ctl_len = 0;
    bit            ctl_err = 0;

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic drive_push(input bit en, input logic [AB-1:0] a);
        if (en) begin
            if (acc_total - disp_total < DEPTH) begin
                acc_total++;
                addr_q.push_back(a);
                exp_ovf = 0;
            end else begin
                exp_ovf = 1;
            end
        end else begin
            exp_ovf = 0;
        end
        i_push      = en;
        i_push_addr = a;
    endtask

    // Monitor: every DUT output event is checked against the scoreboard
    always @(posedge CLK_I) begin
        logic [AB-1:0] a;
        outc_t         o;
        int            exp_cnt;
        cyc++;
        #1;
        if (chk_en) begin
            chk(o_overflow == exp_ovf, "overflow", o_overflow, exp_ovf);
            if (o_stb) begin
                chk(!prev_stb, "stb_width", prev_stb, 0);
                if (addr_q.size() == 0) begin
                    chk(0, "stb_unexpected", o_start_addr, -1);
                end else begin
                    a = addr_q.pop_front();
                    chk(o_start_addr == a, "dispatch_addr", o_start_addr, a);
                end
                disp_total++;
                if (next_exact)
                    chk(cyc == next_min, "gap_exact", cyc, next_min);
                else
                    chk(cyc >= next_min, "gap_min", cyc, next_min);
            end
            exp_cnt = acc_total - disp_total;
            chk(o_count == exp_cnt, "count", o_count, exp_cnt);
            chk(o_full == (exp_cnt == DEPTH), "full", o_full, exp_cnt == DEPTH);
            chk(o_empty == (exp_cnt == 0), "empty", o_empty, exp_cnt == 0);
            if (o_done || o_err) begin
                chk(!(o_done && o_err), "done_err_excl", o_err, 0);
                if (out_q.size() == 0) begin
                    chk(0, "outcome_unexpected", o_err, -1);
                end else begin
                    o = out_q.pop_front();
                    chk(o_err == o.is_err, "outcome_kind", o_err, o.is_err);
                    chk(cyc == o.when, "outcome_time", cyc, o.when);
                    if (o.is_err && err_model < 255) err_model++;
                end
                chk(o_err_count == err_model, "err_count", o_err_count, err_model);
                next_min   = cyc + GAPC + 1;
                next_exact = (acc_total - disp_total) > 0;
            end
        end
        prev_stb = o_stb;
    end

    // Controller model: acks each strobe, or never acks (timeout)
    always @(negedge CLK_I) begin
        outc_t o;
        case (ctl_phase)
            0: begin
                if (o_stb && !RST_I) begin
                    i_error = 1'b0;
                    if (!long_mode && $urandom_range(0, 99) < no_ack_pct) begin
                        o.is_err = 1;
                        o.when   = cyc + AT + 2;
                        out_q.push_back(o);
                    end else begin
                        ctl_wait  = long_mode ? 1 : $urandom_range(1, 3);
                        ctl_len   = long_mode ? 40 : $urandom_range(1, 6);
                        ctl_err   = long_mode ? 0 : ($urandom_range(0, 99) < err_pct);
                        ctl_phase = 1;
                    end
                end
            end
            1: begin
                ctl_wait--;
                if (ctl_wait == 0) begin
                    i_busy    = 1'b1;
                    ctl_phase = 2;
                end
            end
            default: begin
                ctl_len--;
                if (ctl_len == 0) begin
                    i_busy   = 1'b0;
                    i_error  = ctl_err;
                    o.is_err = ctl_err;
                    o.when   = cyc + 1;
                    out_q.push_back(o);
                    ctl_phase = 0;
                end
            end
        endcase
    end

    task automatic run_random(input int n, input int rate);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_I);
            drive_push($urandom_range(0, 99) < rate, AB'($urandom));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((addr_q.size() > 0 || out_q.size() > 0 || ctl_phase != 0)
               && n < 3000) begin
            @(negedge CLK_I);
            drive_push(0, '0);
            n++;
        end
        chk(n < 3000, "drain_timeout", n, 3000);
        repeat (GAPC + 2) begin
            @(negedge CLK_I);
            drive_push(0, '0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(o_stb == 0, {tag, "_stb"}, o_stb, 0);
        chk(o_start_addr == 0, {tag, "_addr"}, o_start_addr, 0);
        chk(o_full == 0, {tag, "_full"}, o_full, 0);
        chk(o_empty == 1, {tag, "_empty"}, o_empty, 1);
        chk(o_count == 0, {tag, "_count"}, o_count, 0);
        chk(o_overflow == 0, {tag, "_ovf"}, o_overflow, 0);
        chk(o_active == 0, {tag, "_active"}, o_active, 0);
        chk(o_done == 0, {tag, "_done"}, o_done, 0);
        chk(o_err == 0, {tag, "_err"}, o_err, 0);
        chk(o_err_count == 0, {tag, "_errcnt"}, o_err_count, 0);
    endtask

    initial begin
        int stb_seen;
        int n;
        repeat (3) @(posedge CLK_I);
        #1;
        chk_reset_vals("reset");
        @(negedge CLK_I);
        RST_I  = 1'b0;
        chk_en = 1;

        // single clean job at 0x10
        @(negedge CLK_I);
        drive_push(1, 8'h10);
        @(negedge CLK_I);
        drive_push(0, '0);
        drain();

        // mixed random traffic with timeouts and controller errors
        no_ack_pct = 15;
        err_pct    = 25;
        run_random(300, 30);
        drain();

        // burst into a busy controller: fill then overflow
        long_mode = 1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK_I);
            drive_push(1, AB'(i));
        end
        @(negedge CLK_I);
        drive_push(0, '0);
        drain();
        long_mode = 0;

        // heavy random traffic
        run_random(400, 60);
        drain();

        // reset while a job sits in DONE with two more queued
        long_mode = 1;
        @(negedge CLK_I);
        drive_push(1, 8'hA1);
        @(negedge CLK_I);
        drive_push(1, 8'hA2);
        @(negedge CLK_I);
        drive_push(1, 8'hA3);
        @(negedge CLK_I);
        drive_push(0, '0);
        n = 0;
        while (!i_busy && n < 50) begin
            @(negedge CLK_I);
            n++;
        end
        chk(n < 50, "busy_wait_timeout", n, 50);
        repeat (3) @(negedge CLK_I);
        chk_en = 0;
        RST_I  = 1'b1;
        @(posedge CLK_I);
        #1;
        err_model = 0;
        chk_reset_vals("midjob_reset");
        @(negedge CLK_I);
        RST_I = 1'b0;
        stb_seen = 0;
        repeat (60) begin
            @(posedge CLK_I);
            #1;
            if (o_stb) stb_seen++;
        end
        chk(stb_seen == 0, "stb_after_reset", stb_seen, 0);
        chk(o_active == 0, "active_after_reset", o_active, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
